// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller.
package dm_pkg;

    // Access size encodings (cpu_size); 2'b11 is illegal.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Controller states.
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] CPU_LOAD = 1'b1;

    // Byte-enable patterns.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Width of the external-requester wait counter (holds MAX_WAIT up to 15).
    localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane logic: store enables/placement, alignment check, load extraction.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [1:0]  ld_lane,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misaligned,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: byte enables, lane replication and alignment check.
    always_comb begin
        be         = BE_NONE;
        wdata_lane = wdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be         = BE_BYTE0 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
                wdata_lane = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                be         = BE_WORD;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Load side: pick the addressed lane and sign/zero extend it.
    always_comb begin
        case (ld_lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = ld_lane[1] ? rdata[31:16] : rdata[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory port owner: arbitrates CPU MEM stage vs. external requester.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_unsigned,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_align_err,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [3:0]        ext_be,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              dm_en,
    output logic [3:0]        dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    logic [0:0]        state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              ext_rvalid_q, ext_rvalid_d;

    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic [31:0]       ld_data;
    logic              misaligned;
    logic              ext_prio;
    logic              cpu_use;
    logic              ext_use;

    // Word address ignores the upper byte-address bits beyond DM depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];

    dm_lane_unit u_lane (
        .addr_lo     (cpu_addr[1:0]),
        .size        (cpu_size),
        .wdata       (cpu_wdata),
        .ld_lane     (lane_q),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .rdata       (dm_rdata),
        .be          (be),
        .wdata_lane  (wdata_lane),
        .misaligned  (misaligned),
        .ld_data     (ld_data)
    );

    assign ext_rvalid = ext_rvalid_q;

    // Next state, arbitration, wait counter and port muxing; all outputs forced low in reset.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        lane_d        = lane_q;
        size_d        = size_q;
        uns_d         = uns_q;
        ext_rvalid_d  = 1'b0;
        cpu_use       = 1'b0;
        ext_use       = 1'b0;
        dm_en         = 1'b0;
        dm_we         = BE_NONE;
        dm_addr       = '0;
        dm_wdata      = '0;
        ext_gnt       = 1'b0;
        ext_rdata     = '0;
        cpu_stall     = 1'b0;
        cpu_align_err = 1'b0;
        cpu_rdata     = '0;
        ext_prio      = ext_req && (wait_cnt_q >= WCNT_W'(MAX_WAIT));

        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    if (cpu_req && misaligned) begin
                        cpu_align_err = 1'b1;
                    end else if (cpu_req && ext_prio) begin
                        cpu_stall = 1'b1;
                    end else if (cpu_req) begin
                        cpu_use = 1'b1;
                        if (!cpu_we) begin
                            cpu_stall = 1'b1;
                            state_d   = CPU_LOAD;
                            lane_d    = cpu_addr[1:0];
                            size_d    = cpu_size;
                            uns_d     = cpu_unsigned;
                        end
                    end
                end
                default: begin
                    // Load data returns; held cpu_req is the same instruction, not a new one.
                    cpu_rdata = ld_data;
                    state_d   = IDLE;
                end
            endcase

            ext_use = ext_req && !cpu_use;
            ext_gnt = ext_use;

            if (cpu_use) begin
                dm_en    = 1'b1;
                dm_we    = cpu_we ? be : BE_NONE;
                dm_addr  = cpu_addr[ADDR_W+1:2];
                dm_wdata = cpu_we ? wdata_lane : '0;
            end else if (ext_use) begin
                dm_en    = 1'b1;
                dm_we    = ext_we ? ext_be : BE_NONE;
                dm_addr  = ext_addr;
                dm_wdata = ext_wdata;
            end

            ext_rvalid_d = ext_use && !ext_we;

            if (!ext_req || ext_use) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q < WCNT_W'(MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end

            if (ext_rvalid_q) begin
                ext_rdata = dm_rdata;
            end
        end
    end

    // State and captured-load registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            lane_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a behavioural byte-writable DM.
module tb_dm_access_ctrl;
    import dm_pkg::*;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req, cpu_we, cpu_unsigned;
    logic [1:0]        cpu_size;
    logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
    logic              cpu_stall, cpu_align_err;
    logic              ext_req, ext_we;
    logic [3:0]        ext_be;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata, ext_rdata;
    logic              ext_gnt, ext_rvalid;
    logic              dm_en;
    logic [3:0]        dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata, dm_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ext_q[$];
    logic [31:0] exp_cpu_q[$];

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .cpu_align_err(cpu_align_err),
        .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    // Synchronous-read, byte-writable RAM model.
    always @(posedge clk) begin
        if (dm_en) begin
            dm_rdata <= mem[dm_addr];
            for (int b = 0; b < 4; b++) begin
                if (dm_we[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
            end
        end
    end

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = SZ_WORD; cpu_unsigned = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_be = 4'h0; ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hFFFF_FFFF;
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 12'h3;
        #7;
        checks++;
        if ({cpu_rdata, cpu_stall, cpu_align_err, ext_gnt, ext_rvalid, ext_rdata,
             dm_en, dm_we, dm_addr, dm_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dm_en=%b dm_we=%b ext_gnt=%b cpu_stall=%b cpu_rdata=%h, required all 0",
                     dm_en, dm_we, ext_gnt, cpu_stall, cpu_rdata);
        end
        next_cycle();
        idle_inputs();
        reset_n = 1'b1;
        settle();
        checks++;
        if ({dm_en, ext_gnt, ext_rvalid, cpu_stall, cpu_align_err, cpu_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: dm_en=%b ext_gnt=%b ext_rvalid=%b cpu_stall=%b, required 0",
                     dm_en, ext_gnt, ext_rvalid, cpu_stall);
        end
    endtask

    task automatic ext_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        next_cycle();
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = a; ext_wdata = d;
        settle();
        checks++;
        if (ext_gnt !== 1'b1 || dm_en !== 1'b1 || dm_we !== 4'hF || dm_addr !== a || dm_wdata !== d) begin
            errors++;
            $display("FAIL ext_write: gnt=%b en=%b we=%b addr=%h wdata=%h, required 1 1 1111 %h %h",
                     ext_gnt, dm_en, dm_we, dm_addr, dm_wdata, a, d);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic ext_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        bit          granted;
        logic [31:0] want;
        next_cycle();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = a;
        exp_ext_q.push_back(exp);
        granted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (ext_gnt === 1'b1) begin
                granted = 1'b1;
                break;
            end
            next_cycle();
        end
        next_cycle();
        ext_req = 1'b0;
        settle();
        checks++;
        if (!granted || ext_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL ext_read_rvalid: granted=%0b ext_rvalid=%b, required 1 1", granted, ext_rvalid);
            exp_ext_q.delete();
        end else begin
            want = exp_ext_q.pop_front();
            checks++;
            if (ext_rdata !== want) begin
                errors++;
                $display("FAIL ext_read_data: ext_rdata=%h, required %h", ext_rdata, want);
            end
        end
    endtask

    task automatic test_store();
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = SZ_BYTE; cpu_addr = 32'h13; cpu_wdata = 32'h0000_00A5;
        settle();
        checks++;
        if (dm_en !== 1'b1 || dm_we !== 4'b1000 || dm_wdata !== 32'hA5A5_A5A5 || dm_addr !== 12'd4 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL store_byte: en=%b we=%b wdata=%h addr=%h stall=%b, required 1 1000 a5a5a5a5 004 0",
                     dm_en, dm_we, dm_wdata, dm_addr, cpu_stall);
        end
        next_cycle();
        cpu_size = SZ_HALF; cpu_addr = 32'h22; cpu_wdata = 32'h1234_BEEF;
        settle();
        checks++;
        if (dm_en !== 1'b1 || dm_we !== 4'b1100 || dm_wdata !== 32'hBEEF_BEEF || dm_addr !== 12'd8 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL store_half: en=%b we=%b wdata=%h addr=%h stall=%b, required 1 1100 beefbeef 008 0",
                     dm_en, dm_we, dm_wdata, dm_addr, cpu_stall);
        end
        next_cycle();
        idle_inputs();
        ext_read(12'd4, 32'hA500_0000);
        ext_read(12'd8, 32'hBEEF_0000);
    endtask

    task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] want;
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = sz; cpu_unsigned = uns; cpu_addr = a;
        exp_cpu_q.push_back(exp);
        settle();
        checks++;
        if (dm_en !== 1'b1 || dm_we !== 4'b0000 || cpu_stall !== 1'b1 || dm_addr !== a[ADDR_W+1:2]) begin
            errors++;
            $display("FAIL load_issue@%h: en=%b we=%b stall=%b addr=%h, required 1 0000 1 %h",
                     a, dm_en, dm_we, cpu_stall, dm_addr, a[ADDR_W+1:2]);
        end
        next_cycle();
        settle();
        want = exp_cpu_q.pop_front();
        checks++;
        if (cpu_rdata !== want || cpu_stall !== 1'b0 || dm_en !== 1'b0) begin
            errors++;
            $display("FAIL load_data@%h sz=%b uns=%b: rdata=%h stall=%b en=%b, required %h 0 0",
                     a, sz, uns, cpu_rdata, cpu_stall, dm_en, want);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_loads();
        do_load(SZ_HALF, 1'b0, 32'h2, 32'hFFFF_8001);
        do_load(SZ_HALF, 1'b1, 32'h2, 32'h0000_8001);
        do_load(SZ_BYTE, 1'b0, 32'h3, 32'hFFFF_FF80);
        do_load(SZ_BYTE, 1'b1, 32'h1, 32'h0000_0012);
        do_load(SZ_WORD, 1'b0, 32'h0, 32'h8001_1234);
        do_load(SZ_HALF, 1'b0, 32'h0, 32'h0000_1234);
    endtask

    task automatic test_ext_starvation();
        logic [31:0] want;
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = SZ_WORD; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd0;
        exp_ext_q.push_back(32'h8001_1234);
        for (int k = 1; k <= int'(MAX_WAIT); k++) begin
            settle();
            checks++;
            if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || dm_we !== 4'hF || dm_addr !== 12'd8) begin
                errors++;
                $display("FAIL starve_cpu_wins_c%0d: gnt=%b stall=%b we=%b addr=%h, required 0 0 1111 008",
                         k, ext_gnt, cpu_stall, dm_we, dm_addr);
            end
            next_cycle();
        end
        settle();
        checks++;
        if (ext_gnt !== 1'b1 || cpu_stall !== 1'b1 || dm_we !== 4'h0 || dm_addr !== 12'd0) begin
            errors++;
            $display("FAIL starve_ext_wins: gnt=%b stall=%b we=%b addr=%h, required 1 1 0000 000",
                     ext_gnt, cpu_stall, dm_we, dm_addr);
        end
        next_cycle();
        ext_addr = 12'd4;
        settle();
        checks++;
        if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || dm_we !== 4'hF) begin
            errors++;
            $display("FAIL starve_wait_cleared: gnt=%b stall=%b we=%b, required 0 0 1111", ext_gnt, cpu_stall, dm_we);
        end
        checks++;
        if (ext_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL starve_rvalid: ext_rvalid=%b, required 1", ext_rvalid);
            exp_ext_q.delete();
        end else begin
            want = exp_ext_q.pop_front();
            checks++;
            if (ext_rdata !== want) begin
                errors++;
                $display("FAIL starve_rdata: ext_rdata=%h, required %h", ext_rdata, want);
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [4];
        logic [31:0] ad [4];
        logic        we [4];
        logic [31:0] want;
        sz[0] = SZ_WORD; ad[0] = 32'h6; we[0] = 1'b0;
        sz[1] = SZ_HALF; ad[1] = 32'h1; we[1] = 1'b1;
        sz[2] = SZ_HALF; ad[2] = 32'h3; we[2] = 1'b0;
        sz[3] = 2'b11;   ad[3] = 32'h0; we[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_we = we[i]; cpu_size = sz[i]; cpu_addr = ad[i]; cpu_wdata = 32'hDEAD_BEEF;
            settle();
            checks++;
            if (cpu_align_err !== 1'b1 || dm_en !== 1'b0 || cpu_stall !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_%0d: align_err=%b en=%b stall=%b, required 1 0 0",
                         i, cpu_align_err, dm_en, cpu_stall);
            end
            next_cycle();
            cpu_req = 1'b0;
            settle();
            checks++;
            if (cpu_align_err !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_pulse_%0d: align_err=%b, required 0", i, cpu_align_err);
            end
        end
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = SZ_WORD; cpu_addr = 32'h6;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd8;
        exp_ext_q.push_back(32'h1234_5678);
        settle();
        checks++;
        if (cpu_align_err !== 1'b1 || ext_gnt !== 1'b1 || dm_addr !== 12'd8 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_ext_shares: align_err=%b gnt=%b addr=%h stall=%b, required 1 1 008 0",
                     cpu_align_err, ext_gnt, dm_addr, cpu_stall);
        end
        next_cycle();
        idle_inputs();
        settle();
        checks++;
        if (ext_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_ext_rvalid: ext_rvalid=%b, required 1", ext_rvalid);
            exp_ext_q.delete();
        end else begin
            want = exp_ext_q.pop_front();
            checks++;
            if (ext_rdata !== want) begin
                errors++;
                $display("FAIL misaligned_ext_rdata: ext_rdata=%h, required %h", ext_rdata, want);
            end
        end
    endtask

    task automatic test_load_vs_ext();
        logic [31:0] want;
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = SZ_WORD; cpu_addr = 32'h0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd4;
        exp_cpu_q.push_back(32'h8001_1234);
        exp_ext_q.push_back(32'hA500_0000);
        settle();
        checks++;
        if (dm_en !== 1'b1 || dm_we !== 4'h0 || dm_addr !== 12'd0 || ext_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL lve_cycle0: en=%b we=%b addr=%h gnt=%b stall=%b, required 1 0000 000 0 1",
                     dm_en, dm_we, dm_addr, ext_gnt, cpu_stall);
        end
        next_cycle();
        settle();
        want = exp_cpu_q.pop_front();
        checks++;
        if (cpu_rdata !== want || cpu_stall !== 1'b0 || ext_gnt !== 1'b1 || dm_addr !== 12'd4) begin
            errors++;
            $display("FAIL lve_cycle1: rdata=%h stall=%b gnt=%b addr=%h, required %h 0 1 004",
                     cpu_rdata, cpu_stall, ext_gnt, dm_addr, want);
        end
        next_cycle();
        idle_inputs();
        settle();
        checks++;
        if (ext_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL lve_rvalid: ext_rvalid=%b, required 1", ext_rvalid);
            exp_ext_q.delete();
        end else begin
            want = exp_ext_q.pop_front();
            checks++;
            if (ext_rdata !== want) begin
                errors++;
                $display("FAIL lve_rdata: ext_rdata=%h, required %h", ext_rdata, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [3];
        logic [31:0]       words [3];
        logic [31:0]       want;
        addrs[0] = 12'd0; words[0] = 32'h8001_1234;
        addrs[1] = 12'd4; words[1] = 32'hA500_0000;
        addrs[2] = 12'd8; words[2] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i < 3) begin
                ext_req = 1'b1; ext_we = 1'b0; ext_addr = addrs[i];
                exp_ext_q.push_back(words[i]);
            end else begin
                idle_inputs();
            end
            settle();
            if (i < 3) begin
                checks++;
                if (ext_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gnt_%0d: ext_gnt=%b, required 1", i, ext_gnt);
                end
            end
            if (i > 0) begin
                checks++;
                if (ext_rvalid !== 1'b1 || exp_ext_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_rvalid_%0d: ext_rvalid=%b, required 1", i, ext_rvalid);
                end else begin
                    want = exp_ext_q.pop_front();
                    checks++;
                    if (ext_rdata !== want) begin
                        errors++;
                        $display("FAIL b2b_rdata_%0d: ext_rdata=%h, required %h", i, ext_rdata, want);
                    end
                end
            end
        end
        next_cycle();
        settle();
        checks++;
        if (ext_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rvalid_end: ext_rvalid=%b, required 0", ext_rvalid);
        end
    endtask

    task automatic test_reset_in_load();
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = SZ_WORD; cpu_addr = 32'h0;
        settle();
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL ril_issue: cpu_stall=%b, required 1", cpu_stall);
        end
        next_cycle();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd4;
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_rdata, cpu_stall, cpu_align_err, ext_gnt, ext_rvalid, ext_rdata,
             dm_en, dm_we, dm_addr, dm_wdata} !== '0) begin
            errors++;
            $display("FAIL ril_outputs: rdata=%h stall=%b gnt=%b en=%b, required all 0",
                     cpu_rdata, cpu_stall, ext_gnt, dm_en);
        end
        next_cycle();
        idle_inputs();
        reset_n = 1'b1;
        settle();
        checks++;
        if (ext_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL ril_no_stale: rvalid=%b rdata=%h stall=%b, required 0 0 0", ext_rvalid, cpu_rdata, cpu_stall);
        end
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = SZ_WORD; cpu_addr = 32'h24; cpu_wdata = 32'h0BAD_F00D;
        settle();
        checks++;
        if (dm_en !== 1'b1 || dm_we !== 4'hF || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL ril_idle_after: en=%b we=%b stall=%b, required 1 1111 0", dm_en, dm_we, cpu_stall);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        ext_write(12'd0, 32'h8001_1234);
        ext_write(12'd4, 32'h0000_0000);
        ext_write(12'd8, 32'h0000_0000);
        test_store();
        test_loads();
        test_ext_starvation();
        test_misaligned();
        test_load_vs_ext();
        test_back_to_back();
        test_reset_in_load();
        checks++;
        if (exp_ext_q.size() != 0 || exp_cpu_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: ext=%0d cpu=%0d left, required 0 0", exp_ext_q.size(), exp_cpu_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Owns the single data-memory (DM) port.
- Shares that port between the MEM-stage CPU requester and an external requester (debug/DMA bridge), sequencing each access.
- Generates byte enables, store lane placement and load extraction. Stalls the pipeline while a load is in flight or the port is lost to arbitration.
- DM is a synchronous-read, byte-writable word RAM with 1-cycle read latency.

Parameters:
- ADDR_W, 12: DM word-address width (DM depth = 2^ADDR_W words).
- MAX_WAIT, 4: cycles the external requester may be refused before it takes priority over the CPU (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM-stage memory instruction valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- cpu_unsigned  in  1  load zero-extends (lbu/lhu).
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_rdata  out  32  extended load result, valid while state is CPU_LOAD.
- cpu_stall  out  1  hold pipeline this cycle.
- cpu_align_err  out  1  misaligned access, 1-cycle, no memory effect.
- ext_req  in  1  external access request, held until granted.
- ext_we  in  1  external write.
- ext_be  in  4  external byte enables, used as-is.
- ext_addr  in  ADDR_W  external word address.
- ext_wdata  in  32  external write data.
- ext_gnt  out  1  access performed this cycle.
- ext_rvalid  out  1  ext_rdata valid; exactly one cycle after a granted read.
- ext_rdata  out  32  raw DM word.
- dm_en  out  1  DM access strobe.
- dm_we  out  4  DM byte write enables.
- dm_addr  out  ADDR_W  DM word address (cpu_addr[ADDR_W+1:2] for CPU accesses).
- dm_wdata  out  32  lane-placed write data.
- dm_rdata  in  32  DM read data, valid one cycle after dm_en with dm_we = 0.

Behaviour:
- While reset_n is low: every output 0, state IDLE, wait_cnt 0, captured lane/size/unsigned 0. Reset during CPU_LOAD abandons the load.
- FSM states: IDLE and CPU_LOAD. dm_*, ext_gnt, cpu_stall, cpu_align_err and cpu_rdata are combinational from state, registers and inputs. ext_rvalid and ext_rdata path control are registered.
- Alignment check:
  - Half access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
  - Size 11 is misaligned.
  - Misaligned cpu_req in IDLE: cpu_align_err = 1, cpu_stall = 0, no CPU DM access; the port may serve ext that cycle.
- cpu_ok means cpu_req is set, the access is aligned, and NOT (ext_req and wait_cnt >= MAX_WAIT).
- IDLE, cpu_ok store: dm_en = 1, dm_we = BE, single cycle, cpu_stall = 0.
  - BE for word: 1111.
  - BE for half: 0011 if addr[1] = 0, 1100 if addr[1] = 1.
  - BE for byte: one-hot 0001/0010/0100/1000 selected by addr[1:0].
  - dm_wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- IDLE, cpu_ok load: dm_en = 1, dm_we = 0000, cpu_stall = 1. Capture addr[1:0], size and unsigned; next state CPU_LOAD.
- CPU_LOAD:
  - cpu_stall = 0.
  - cpu_rdata = selected lane of dm_rdata, sign- or zero-extended per the captured fields.
  - The still-present cpu_req is ignored (not reissued).
  - The port is free for ext.
  - Next state IDLE.
- IDLE, aligned cpu_req refused because ext has priority: cpu_stall = 1, no CPU access.
- ext is granted when ext_req is set and the port is not used by the CPU this cycle. On grant: dm_en = 1, dm_we = ext_we ? ext_be : 0000, dm_wdata = ext_wdata. A granted read sets ext_rvalid next cycle with ext_rdata = dm_rdata.
- wait_cnt:
  - +1 (saturating at MAX_WAIT) on each cycle with ext_req and no ext_gnt.
  - Cleared on ext_gnt.
  - Cleared when ext_req is low.
- Simultaneous CPU and ext requests: the CPU wins unless wait_cnt >= MAX_WAIT. Ext is therefore served within MAX_WAIT+1 cycles. Back-to-back loads lose at most one ext slot each.
- Back-to-back reads from either side are legal; dm_rdata always belongs to the previous cycle's issuer.

Decomposition:
- Package dm_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum (IDLE, CPU_LOAD);
  - the BE constants.
- Sub-module dm_lane_unit (combinational): from addr[1:0], size and data, produce BE, lane-placed write data, misaligned flag, and extended load data.
- FSM, arbitration and wait counter live in dm_access_ctrl.

Test Plan:
- sb at addr 0x13, wdata 0x000000A5 -> dm_we 1000, dm_wdata 0xA5A5A5A5, dm_addr 4, cpu_stall 0.
- lh at addr 0x2, dm_rdata 0x8001xxxx: cycle 0 dm_en = 1, dm_we = 0, cpu_stall = 1. Cycle 1 cpu_rdata 0xFFFF8001, cpu_stall = 0. Repeat as lhu -> 0x00008001.
- lw at addr 0x6 -> cpu_align_err = 1 for one cycle, dm_en = 0, cpu_stall = 0. sh at addr 0x1 -> same.
- CPU store every cycle while ext_req is held (MAX_WAIT = 4): ext_gnt in the 5th cycle, cpu_stall = 1 in that cycle, wait_cnt back to 0 after.
- CPU lw issued in the same cycle as an ext read request: the lw is granted; ext is granted in the CPU_LOAD cycle; ext_rvalid the next cycle with the correct word.
- reset_n pulsed low during CPU_LOAD -> all outputs 0 immediately; state IDLE after release; no stale cpu_rdata or ext_rvalid.
